// File: rtl/fb_cell_if.sv
// Command and pixel-write bundle between game logic, the frame-buffer writer
// and the RAM port arbiter.
//
// Command handshake: the writer takes a command at a rising clk edge where
// cmd_valid and cmd_ready are both high. cmd_clear, cmd_x, cmd_y and
// cmd_color are captured at that edge and may change freely afterwards.
// cmd_ready only reflects the writer's state and never depends on cmd_valid.
// The pixel side has no ready: wr_en is a registered strobe and the arbiter
// holds the stream off by raising wr_stall.
interface fb_cell_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [5:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [11:0] cmd_color;
  logic        wr_stall;
  logic        wr_en;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [0:0]  dbg_state;

  // Game logic / arbiter side
  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_color, wr_stall,
    input  cmd_ready, wr_en, wr_row, wr_col, wr_data, busy, done, err, dbg_state
  );

  // Frame-buffer writer side
  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_color, wr_stall,
    output cmd_ready, wr_en, wr_row, wr_col, wr_data, busy, done, err, dbg_state
  );
endinterface

// File: rtl/fb_cell_writer.sv
// Frame-buffer writer: expands cell-draw and screen-clear commands into a
// row-major stream of single-pixel RAM writes, one per unstalled cycle.
module fb_cell_writer #(
  parameter int CELL_W    = 16,
  parameter int GRID_COLS = 40,
  parameter int GRID_ROWS = 30
) (
  input  logic      clk,
  input  logic      rst,
  fb_cell_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam int CW_LOG = $clog2(CELL_W);

  localparam logic [5:0] COLS_LIM      = 6'(GRID_COLS);
  localparam logic [4:0] ROWS_LIM      = 5'(GRID_ROWS);
  localparam logic [8:0] CLR_ROW_LAST  = 9'(GRID_ROWS * CELL_W - 1);
  localparam logic [9:0] CLR_COL_LAST  = 10'(GRID_COLS * CELL_W - 1);
  localparam logic [8:0] CELL_ROW_LAST = 9'(CELL_W - 1);
  localparam logic [9:0] CELL_COL_LAST = 10'(CELL_W - 1);

  logic [0:0]  state_q, state_d;
  logic        clear_q, clear_d;
  logic [8:0]  base_row_q, base_row_d;
  logic [9:0]  base_col_q, base_col_d;
  logic [11:0] color_q, color_d;
  logic [8:0]  py_q, py_d;
  logic [9:0]  px_q, px_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_row_q, wr_row_d;
  logic [9:0]  wr_col_q, wr_col_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        in_range;
  logic [8:0]  py_last;
  logic [9:0]  px_last;

  // Next-state logic: command capture in IDLE, pixel stepping in FILL.
  always_comb begin
    state_d    = state_q;
    clear_d    = clear_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    color_d    = color_q;
    py_d       = py_q;
    px_d       = px_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    accept   = bus.cmd_valid && (state_q == S_IDLE);
    in_range = (bus.cmd_x < COLS_LIM) && (bus.cmd_y < ROWS_LIM);
    // A clear walks the whole screen from base (0,0); a cell walks one tile.
    py_last  = clear_q ? CLR_ROW_LAST : CELL_ROW_LAST;
    px_last  = clear_q ? CLR_COL_LAST : CELL_COL_LAST;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_clear) begin
            state_d    = S_FILL;
            clear_d    = 1'b1;
            base_row_d = '0;
            base_col_d = '0;
            color_d    = bus.cmd_color;
            py_d       = '0;
            px_d       = '0;
          end else if (in_range) begin
            state_d    = S_FILL;
            clear_d    = 1'b0;
            base_row_d = 9'(bus.cmd_y) << CW_LOG;
            base_col_d = 10'(bus.cmd_x) << CW_LOG;
            color_d    = bus.cmd_color;
            py_d       = '0;
            px_d       = '0;
          end else begin
            // Rejected cell: no pixels, just the completion/error pulse.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (!bus.wr_stall) begin
          wr_en_d   = 1'b1;
          wr_row_d  = base_row_q + py_q;
          wr_col_d  = base_col_q + px_q;
          wr_data_d = color_q;
          if (px_q == px_last) begin
            px_d = '0;
            if (py_q == py_last) begin
              // Final pixel: done lands in the same cycle as this write.
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              py_d = py_q + 9'd1;
            end
          end else begin
            px_d = px_q + 10'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any fill in progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clear_q    <= 1'b0;
      base_row_q <= '0;
      base_col_q <= '0;
      color_q    <= '0;
      py_q       <= '0;
      px_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clear_q    <= clear_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      color_q    <= color_d;
      py_q       <= py_d;
      px_q       <= px_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_FILL);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fb_cell_writer.sv
// Bench for fb_cell_writer: full-size instance for cell, stall, reset and
// partial-clear scenarios; a 16x12 instance (CELL_W=4) for a complete clear.
module tb_fb_cell_writer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  fb_cell_if bus_m ();
  fb_cell_if bus_s ();

  fb_cell_writer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  fb_cell_writer #(.CELL_W(4), .GRID_COLS(4), .GRID_ROWS(3)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // Expected writes {row, col, data} and completion events per instance
  logic [30:0] exp_q[$];
  logic [30:0] exp_s_q[$];
  int          done_cyc_q[$];
  bit          done_err_q[$];
  int          done_cyc_s_q[$];
  bit          done_err_s_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Push `limit` pixels of a h x w rectangle at (r0,c0) in row-major order
  task automatic push_rect(input bit sel, input int r0, input int c0, input int h,
                           input int w, input logic [11:0] color, input int limit);
    int n;
    logic [30:0] e;
    n = 0;
    for (int r = 0; r < h && n < limit; r++) begin
      for (int c = 0; c < w && n < limit; c++) begin
        e = {9'(r0 + r), 10'(c0 + c), color};
        if (sel) exp_s_q.push_back(e);
        else     exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic push_done(input bit sel, input int at_cyc, input bit is_err);
    if (sel) begin
      done_cyc_s_q.push_back(at_cyc);
      done_err_s_q.push_back(is_err);
    end else begin
      done_cyc_q.push_back(at_cyc);
      done_err_q.push_back(is_err);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a command (leaves cmd_valid high) and returns the cycle index
  // right after the accepting edge.
  task automatic send(input bit sel, input bit clr, input logic [5:0] x, input logic [4:0] y,
                      input logic [11:0] color, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    if (sel) begin
      bus_s.cmd_clear = clr; bus_s.cmd_x = x; bus_s.cmd_y = y;
      bus_s.cmd_color = color; bus_s.cmd_valid = 1'b1;
    end else begin
      bus_m.cmd_clear = clr; bus_m.cmd_x = x; bus_m.cmd_y = y;
      bus_m.cmd_color = color; bus_m.cmd_valid = 1'b1;
    end
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (sel ? bus_s.cmd_ready : bus_m.cmd_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
      end
    end
    if (!ok) flag("send_accept", "command never accepted");
  endtask

  // Drops cmd_valid and scrambles the command fields, which must be ignored
  task automatic release_cmd(input bit sel);
    if (sel) begin
      bus_s.cmd_valid = 1'b0; bus_s.cmd_clear = 1'($urandom_range(0, 1));
      bus_s.cmd_x = 6'($urandom_range(0, 63)); bus_s.cmd_y = 5'($urandom_range(0, 31));
      bus_s.cmd_color = 12'($urandom_range(0, 4095));
    end else begin
      bus_m.cmd_valid = 1'b0; bus_m.cmd_clear = 1'($urandom_range(0, 1));
      bus_m.cmd_x = 6'($urandom_range(0, 63)); bus_m.cmd_y = 5'($urandom_range(0, 31));
      bus_m.cmd_color = 12'($urandom_range(0, 4095));
    end
  endtask

  // Waits (bounded) until every expected write and done for `sel` was seen
  task automatic wait_idle(input bit sel, input int budget);
    int n;
    n = 0;
    while (n < budget && (sel ? (exp_s_q.size() + done_cyc_s_q.size())
                              : (exp_q.size() + done_cyc_q.size())) != 0) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      flag("wait_idle", "expected writes/done never appeared");
      exp_q.delete(); exp_s_q.delete();
      done_cyc_q.delete(); done_err_q.delete();
      done_cyc_s_q.delete(); done_err_s_q.delete();
    end
    #1;
  endtask

  task automatic wait_edges_until(input int target);
    for (int n = 0; n < 1000 && cyc < target; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts rst mid-fill and checks the asynchronous drop and reset values
  task automatic abort_with_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_wr_en_async_drop"}, 32'(bus_m.wr_en), 32'd0);
    check({tag, "_busy_in_reset"}, 32'(bus_m.busy), 32'd0);
    check({tag, "_ready_in_reset"}, 32'(bus_m.cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check({tag, "_wr_row_reset"}, 32'(bus_m.wr_row), 32'd0);
    check({tag, "_wr_col_reset"}, 32'(bus_m.wr_col), 32'd0);
    check({tag, "_wr_data_reset"}, 32'(bus_m.wr_data), 32'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  // Full-size instance: pop and compare on every write and every done/err
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_m.wr_en) begin
        if (exp_q.size() == 0) flag("write_m", "unexpected write");
        else check("write_m", {1'b0, bus_m.wr_row, bus_m.wr_col, bus_m.wr_data}, {1'b0, exp_q.pop_front()});
      end
      if (bus_m.done || bus_m.err) begin
        if (done_cyc_q.size() == 0) flag("done_m", "unexpected done/err");
        else begin
          bit e;
          e = done_err_q.pop_front();
          check("done_cycle_m", 32'(cyc), 32'(done_cyc_q.pop_front()));
          check("done_err_m", {30'd0, bus_m.done, bus_m.err}, {30'd0, 1'b1, e});
          check("done_with_last_write_m", 32'(bus_m.wr_en), 32'(!e));
        end
      end
    end
  end

  // Reduced-size instance
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_s.wr_en) begin
        if (exp_s_q.size() == 0) flag("write_s", "unexpected write");
        else check("write_s", {1'b0, bus_s.wr_row, bus_s.wr_col, bus_s.wr_data}, {1'b0, exp_s_q.pop_front()});
      end
      if (bus_s.done || bus_s.err) begin
        if (done_cyc_s_q.size() == 0) flag("done_s", "unexpected done/err");
        else begin
          bit e;
          e = done_err_s_q.pop_front();
          check("done_cycle_s", 32'(cyc), 32'(done_cyc_s_q.pop_front()));
          check("done_err_s", {30'd0, bus_s.done, bus_s.err}, {30'd0, 1'b1, e});
          check("done_with_last_write_s", 32'(bus_s.wr_en), 32'(!e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc2;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus_m.cmd_valid = 1'b0; bus_m.cmd_clear = 1'b0; bus_m.cmd_x = '0;
    bus_m.cmd_y = '0; bus_m.cmd_color = '0; bus_m.wr_stall = 1'b0;
    bus_s.cmd_valid = 1'b0; bus_s.cmd_clear = 1'b0; bus_s.cmd_x = '0;
    bus_s.cmd_y = '0; bus_s.cmd_color = '0; bus_s.wr_stall = 1'b0;

    // Reset values, with a command offered while rst is high
    #2;
    bus_m.cmd_x = 6'd1; bus_m.cmd_y = 5'd1; bus_m.cmd_color = 12'hABC; bus_m.cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 32'(bus_m.wr_en), 32'd0);
    check("reset_wr_row", 32'(bus_m.wr_row), 32'd0);
    check("reset_wr_col", 32'(bus_m.wr_col), 32'd0);
    check("reset_wr_data", 32'(bus_m.wr_data), 32'd0);
    check("reset_busy", 32'(bus_m.busy), 32'd0);
    check("reset_done_err", {30'd0, bus_m.done, bus_m.err}, 32'd0);
    check("reset_cmd_ready", 32'(bus_m.cmd_ready), 32'd1);
    bus_m.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("no_accept_in_reset_busy", 32'(bus_m.busy), 32'd0);
    check("no_accept_in_reset_ready", 32'(bus_m.cmd_ready), 32'd1);

    // Cell (0,0), colour 00F
    push_rect(1'b0, 0, 0, 16, 16, 12'h00F, 256);
    send(1'b0, 1'b0, 6'd0, 5'd0, 12'h00F, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc + 256, 1'b0);
    wait_idle(1'b0, 2000);

    // Cell (39,29), colour F0F: bottom-right corner
    push_rect(1'b0, 464, 624, 16, 16, 12'hF0F, 256);
    send(1'b0, 1'b0, 6'd39, 5'd29, 12'hF0F, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc + 256, 1'b0);
    wait_idle(1'b0, 2000);

    // Cell (40,0): rejected, done+err in the cycle after acceptance
    send(1'b0, 1'b0, 6'd40, 5'd0, 12'h123, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc, 1'b1);
    @(negedge clk);
    check("oor_x_cmd_ready", 32'(bus_m.cmd_ready), 32'd1);
    wait_idle(1'b0, 50);

    // Cell (0,30): row out of range
    send(1'b0, 1'b0, 6'd0, 5'd30, 12'h456, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc, 1'b1);
    wait_idle(1'b0, 50);

    // Cell (5,3) with 3 stalled cycles at write 50
    push_rect(1'b0, 48, 80, 16, 16, 12'h0A5, 256);
    send(1'b0, 1'b0, 6'd5, 5'd3, 12'h0A5, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc + 259, 1'b0);
    wait_edges_until(acc + 50);
    bus_m.wr_stall = 1'b1;
    wait_edges_until(acc + 53);
    bus_m.wr_stall = 1'b0;
    wait_idle(1'b0, 2000);

    // Cell (7,7) with a stall on the final pixel
    push_rect(1'b0, 112, 112, 16, 16, 12'h7E7, 256);
    send(1'b0, 1'b0, 6'd7, 5'd7, 12'h7E7, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc + 257, 1'b0);
    wait_edges_until(acc + 255);
    bus_m.wr_stall = 1'b1;
    wait_edges_until(acc + 256);
    bus_m.wr_stall = 1'b0;
    wait_idle(1'b0, 2000);

    // Back-to-back: cmd_valid held high, second accepted in the done cycle
    push_rect(1'b0, 160, 160, 16, 16, 12'h111, 256);
    push_rect(1'b0, 160, 176, 16, 16, 12'h222, 256);
    send(1'b0, 1'b0, 6'd10, 5'd10, 12'h111, acc);
    push_done(1'b0, acc + 256, 1'b0);
    send(1'b0, 1'b0, 6'd11, 5'd10, 12'h222, acc2);
    release_cmd(1'b0);
    check("b2b_accept_cycle", 32'(acc2), 32'(acc + 257));
    push_done(1'b0, acc2 + 256, 1'b0);
    wait_idle(1'b0, 2000);

    // Reset during cell (2,2) after 100 writes, then cell (1,1)
    push_rect(1'b0, 32, 32, 16, 16, 12'hC3C, 100);
    send(1'b0, 1'b0, 6'd2, 5'd2, 12'hC3C, acc);
    release_cmd(1'b0);
    wait_idle(1'b0, 500);
    abort_with_reset("rst_cell");
    push_rect(1'b0, 16, 16, 16, 16, 12'h3C3, 256);
    send(1'b0, 1'b0, 6'd1, 5'd1, 12'h3C3, acc);
    release_cmd(1'b0);
    push_done(1'b0, acc + 256, 1'b0);
    wait_idle(1'b0, 2000);

    // Full-size clear: first 1300 pixels (crosses two row wraps), then abort
    push_rect(1'b0, 0, 0, 480, 640, 12'h5A3, 1300);
    send(1'b0, 1'b1, 6'd63, 5'd31, 12'h5A3, acc);
    release_cmd(1'b0);
    wait_idle(1'b0, 3000);
    abort_with_reset("rst_clear");

    // Small screen (16x12): full clear, last pixel (11,15) with done
    push_rect(1'b1, 0, 0, 12, 16, 12'h000, 192);
    send(1'b1, 1'b1, 6'd2, 5'd1, 12'h000, acc);
    release_cmd(1'b1);
    push_done(1'b1, acc + 192, 1'b0);
    wait_idle(1'b1, 1000);

    // Small screen: corner cell (3,2) and rejected cell (4,0)
    push_rect(1'b1, 8, 12, 4, 4, 12'hE21, 16);
    send(1'b1, 1'b0, 6'd3, 5'd2, 12'hE21, acc);
    release_cmd(1'b1);
    push_done(1'b1, acc + 16, 1'b0);
    wait_idle(1'b1, 200);
    send(1'b1, 1'b0, 6'd4, 5'd0, 12'hFFF, acc);
    release_cmd(1'b1);
    push_done(1'b1, acc, 1'b1);
    wait_idle(1'b1, 50);

    // Quiet tail: no stray writes or pulses
    repeat (5) @(posedge clk);
    #1;
    check("end_queue_m", 32'(exp_q.size() + done_cyc_q.size()), 32'd0);
    check("end_queue_s", 32'(exp_s_q.size() + done_cyc_s_q.size()), 32'd0);
    check("end_idle_m", {29'd0, bus_m.wr_en, bus_m.busy, bus_m.cmd_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

endmodule
